// File: rtl/vga_pin_pkg.sv
// rtl/vga_pin_pkg.sv - shared constants and helpers for the VGA pin driver
package vga_pin_pkg;

  localparam logic [1:0] BAYER [0:1][0:1] = '{'{2'd0, 2'd2}, '{2'd3, 2'd1}};

  // Scales a 2-bit Bayer threshold to the LSB weight dropped by quantisation
  function automatic int unsigned scale_offset(input logic [1:0] t, input int unsigned d);
    if (d >= 2) return int'(t) << (d - 2);
    return int'(t) >> (2 - d);
  endfunction

  function automatic int unsigned hold_cnt_width(input int unsigned hold);
    return (hold == 0) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/vga_pin_driver_reset_stretcher.sv
// rtl/vga_pin_driver_reset_stretcher.sv - stretches rst into a registered active-low core reset
module reset_stretcher
  import vga_pin_pkg::*;
#(
  parameter int HOLD_CYCLES = 3
) (
  input  logic clk48,
  input  logic rst,
  output logic core_rst_n
);

  localparam int CW = hold_cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD = CW'(HOLD_CYCLES);

  // Power-up values keep the core in reset even if rst never pulses
  logic [CW-1:0] hold_cnt = HOLD;
  logic          rst_n_q  = 1'b0;

  always_ff @(posedge clk48) begin
    if (rst) begin
      hold_cnt <= HOLD;
      rst_n_q  <= 1'b0;
    end else begin
      if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      rst_n_q <= (hold_cnt == '0);
    end
  end

  assign core_rst_n = rst_n_q;

endmodule

// File: rtl/vga_pin_driver.sv
// rtl/vga_pin_driver.sv - video pin stage: reset stretch, 2x2 dither (VGA_PIN_DITHER_EN), sync polarity
module vga_pin_driver
  import vga_pin_pkg::*;
#(
  parameter int BPC_IN      = 4,
  parameter int BPC_OUT     = 2,
  parameter int HOLD_CYCLES = 3,
  parameter int HSYNC_NEG   = 1,
  parameter int VSYNC_NEG   = 1
) (
  input  logic               clk48,
  input  logic               rst,
  output logic               core_rst_n,
  input  logic [BPC_IN-1:0]  r_in,
  input  logic [BPC_IN-1:0]  g_in,
  input  logic [BPC_IN-1:0]  b_in,
  input  logic               de_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic [BPC_OUT-1:0] r_out,
  output logic [BPC_OUT-1:0] g_out,
  output logic [BPC_OUT-1:0] b_out,
  output logic               hsync_out,
  output logic               vsync_out
);

  localparam int D  = BPC_IN - BPC_OUT;
  localparam int SW = BPC_IN + 1;
  localparam logic [BPC_OUT-1:0] OMAX = '1;
  localparam logic HS_IDLE = (HSYNC_NEG != 0);
  localparam logic VS_IDLE = (VSYNC_NEG != 0);

  logic          blank;
  logic [SW-1:0] off_next;

  reset_stretcher #(.HOLD_CYCLES(HOLD_CYCLES)) u_reset_stretcher (
    .clk48      (clk48),
    .rst        (rst),
    .core_rst_n (core_rst_n)
  );

  assign blank = rst || !core_rst_n;

`ifdef VGA_PIN_DITHER_EN
  logic px_q = 1'b0, py_q = 1'b0, de_prev = 1'b0, vs_prev = 1'b0;
  logic px_cur, py_cur, vs_rise;

  always_comb begin
    vs_rise  = vsync_in && !vs_prev;
    px_cur   = (de_in && !de_prev) ? 1'b0 : px_q;
    py_cur   = vs_rise ? 1'b0 : py_q;
    off_next = SW'(scale_offset(BAYER[py_cur][px_cur], D));
  end

  // A vsync rise clears line parity even when a line ends in the same cycle
  always_ff @(posedge clk48) begin
    if (rst) begin
      px_q    <= 1'b0;
      py_q    <= 1'b0;
      de_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      de_prev <= de_in;
      vs_prev <= vsync_in;
      if (de_in) px_q <= !px_cur;
      if (vs_rise) py_q <= 1'b0;
      else if (!de_in && de_prev) py_q <= !py_q;
    end
  end
`else
  assign off_next = '0;
`endif

  logic [BPC_IN-1:0] r1 = '0, g1 = '0, b1 = '0;
  logic              de1 = 1'b0, hs1 = 1'b0, vs1 = 1'b0;
  logic [SW-1:0]     off1 = '0;

  always_ff @(posedge clk48) begin
    if (blank) begin
      r1   <= '0;
      g1   <= '0;
      b1   <= '0;
      de1  <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      off1 <= '0;
    end else begin
      r1   <= r_in;
      g1   <= g_in;
      b1   <= b_in;
      de1  <= de_in;
      hs1  <= hsync_in;
      vs1  <= vsync_in;
      off1 <= off_next;
    end
  end

  // Sum is one bit wider than the input so full scale plus offset saturates instead of wrapping
  function automatic logic [BPC_OUT-1:0] quant(input logic [BPC_IN-1:0] c, input logic [SW-1:0] o);
    logic [SW-1:0] s;
    s = ({1'b0, c} + o) >> D;
    if (s > SW'(OMAX)) return OMAX;
    return s[BPC_OUT-1:0];
  endfunction

  logic [BPC_OUT-1:0] r_q = '0, g_q = '0, b_q = '0;
  logic               hs_q = HS_IDLE, vs_q = VS_IDLE;

  always_ff @(posedge clk48) begin
    if (rst) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= HS_IDLE;
      vs_q <= VS_IDLE;
    end else begin
      r_q  <= de1 ? quant(r1, off1) : '0;
      g_q  <= de1 ? quant(g1, off1) : '0;
      b_q  <= de1 ? quant(b1, off1) : '0;
      hs_q <= hs1 ^ HS_IDLE;
      vs_q <= vs1 ^ VS_IDLE;
    end
  end

  assign r_out     = r_q;
  assign g_out     = g_q;
  assign b_out     = b_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;

endmodule

// File: tb/tb_vga_pin_driver.sv
// tb/tb_vga_pin_driver.sv - randomized bench for vga_pin_driver against a latency/quantisation model
module tb_vga_pin_driver;

  localparam int BPC_IN  = 4;
  localparam int BPC_OUT = 2;
  localparam int HOLD    = 3;
  localparam int D       = BPC_IN - BPC_OUT;
  localparam int OMAXI   = (1 << BPC_OUT) - 1;
  localparam int N       = 600;

  logic clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  logic              rst = 1'b0;
  logic [BPC_IN-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic              de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;

  logic               core_rst_n, hsync_out, vsync_out;
  logic [BPC_OUT-1:0] r_out, g_out, b_out;
  logic               core_rst_n_p, hsync_out_p, vsync_out_p;
  logic [BPC_OUT-1:0] r_out_p, g_out_p, b_out_p;

  vga_pin_driver dut (
    .clk48(clk48), .rst(rst), .core_rst_n(core_rst_n),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  vga_pin_driver #(.HSYNC_NEG(0), .VSYNC_NEG(1)) dut_p (
    .clk48(clk48), .rst(rst), .core_rst_n(core_rst_n_p),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .r_out(r_out_p), .g_out(g_out_p), .b_out(b_out_p),
    .hsync_out(hsync_out_p), .vsync_out(vsync_out_p)
  );

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Per-edge record of what the DUT sampled, plus model state
  int rec_r[N], rec_g[N], rec_b[N], rec_off[N];
  bit rec_de[N], rec_hs[N], rec_vs[N], rec_rst[N], core_after[N];
  int bayer[2][2] = '{'{0, 2}, '{3, 1}};
  int k = 0, last_rst = 0, x_idx = 0, line_idx = 0;
  bit prev_de = 0, prev_vs = 0;

  function automatic int scale(input int t);
    if (D >= 2) return t * (1 << (D - 2));
    return t / (1 << (2 - D));
  endfunction

  function automatic int quant(input int c, input int o);
    int v;
    v = (c + o) / (1 << D);
    return (v > OMAXI) ? OMAXI : v;
  endfunction

  task automatic cycle();
    int px, py, j, er, eg, eb;
    bit hs_l, vs_l, core_e;
    k++;
    rec_r[k] = int'(r_in); rec_g[k] = int'(g_in); rec_b[k] = int'(b_in);
    rec_de[k] = de_in; rec_hs[k] = hsync_in; rec_vs[k] = vsync_in; rec_rst[k] = rst;
    px = (de_in && !prev_de) ? 0 : x_idx % 2;
    py = (vsync_in && !prev_vs) ? 0 : line_idx % 2;
`ifdef VGA_PIN_DITHER_EN
    rec_off[k] = scale(bayer[py][px]);
`else
    rec_off[k] = 0;
`endif
    if (rst) begin
      x_idx = 0; line_idx = 0; prev_de = 0; prev_vs = 0; last_rst = k;
    end else begin
      if (de_in) x_idx = px + 1;
      if (vsync_in && !prev_vs) line_idx = 0;
      else if (!de_in && prev_de) line_idx++;
      prev_de = de_in; prev_vs = vsync_in;
    end
    core_e = (k - last_rst >= HOLD + 1);
    core_after[k] = core_e;
    er = 0; eg = 0; eb = 0; hs_l = 0; vs_l = 0;
    if (!rst && k >= 2) begin
      j = k - 1;
      if (!rec_rst[j] && core_after[j-1]) begin
        hs_l = rec_hs[j]; vs_l = rec_vs[j];
        if (rec_de[j]) begin
          er = quant(rec_r[j], rec_off[j]);
          eg = quant(rec_g[j], rec_off[j]);
          eb = quant(rec_b[j], rec_off[j]);
        end
      end
    end
    @(posedge clk48);
    #1;
    check("core_rst_n", 8'(core_rst_n), 8'(core_e));
    check("r_out", 8'(r_out), 8'(er));
    check("g_out", 8'(g_out), 8'(eg));
    check("b_out", 8'(b_out), 8'(eb));
    check("hsync_out", 8'(hsync_out), 8'(!hs_l));
    check("vsync_out", 8'(vsync_out), 8'(!vs_l));
    check("core_rst_n_p", 8'(core_rst_n_p), 8'(core_e));
    check("r_out_p", 8'(r_out_p), 8'(er));
    check("g_out_p", 8'(g_out_p), 8'(eg));
    check("b_out_p", 8'(b_out_p), 8'(eb));
    check("hsync_out_p", 8'(hsync_out_p), 8'(hs_l));
    check("vsync_out_p", 8'(vsync_out_p), 8'(!vs_l));
  endtask

  function automatic logic [BPC_IN-1:0] pick();
    case ($urandom_range(0, 4))
      0: return 4'hF;
      1: return 4'h5;
      2: return 4'hB;
      3: return 4'h0;
      default: return 4'($urandom);
    endcase
  endfunction

  task automatic apply(input bit r, input bit de, input bit hs, input bit vs, input logic [BPC_IN-1:0] c);
    rst = r; de_in = de; hsync_in = hs; vsync_in = vs;
    r_in = c; g_in = pick(); b_in = pick();
    cycle();
  endtask

  task automatic random_run(input int n, input int rst_at);
    bit de_st = 0;
    int run = 0;
    for (int i = 0; i < n; i++) begin
      if (run == 0) begin
        de_st = !de_st;
        run = de_st ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 4));
      end
      run--;
      apply(i >= rst_at && i < rst_at + 5, de_st, $urandom_range(0, 5) == 0,
            $urandom_range(0, 15) == 0, pick());
    end
  endtask

  initial begin
    // Power-on without any rst pulse
    for (int i = 0; i < 6; i++) apply(0, $urandom_range(0, 1) == 1, 1, 1, pick());
    apply(0, 0, 0, 0, 4'h0);
    apply(0, 0, 0, 0, 4'h0);
    // 2x2 block with de rise coinciding with vsync rise, then full-scale block
    for (int c = 0; c < 2; c++) begin
      apply(0, 1, 0, 1, c == 0 ? 4'h5 : 4'hF);
      apply(0, 1, 0, 0, c == 0 ? 4'h5 : 4'hF);
      apply(0, 0, 1, 0, 4'hF);
      apply(0, 0, 0, 0, 4'hF);
      apply(0, 1, 0, 0, c == 0 ? 4'h5 : 4'hF);
      apply(0, 1, 0, 0, c == 0 ? 4'h5 : 4'hF);
      apply(0, 0, 0, 0, 4'hB);
      apply(0, 0, 0, 0, 4'hB);
    end
    apply(0, 1, 0, 0, 4'hB);
    apply(0, 0, 0, 0, 4'hF);
    random_run(300, 150);
    random_run(100, 1000);
    apply(0, 0, 0, 0, 4'h0);
    apply(0, 0, 0, 0, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_pin_driver.md
Name: vga_pin_driver

Overview:
- Board-level video output stage between the vgademo core and the FPGA pins.
- Generates a stretched power-on/user reset for the core.
- Reduces BPC_IN-bit colour to BPC_OUT-bit pin colour using optional 2x2 ordered dithering.
- Applies per-signal sync polarity, blanks outputs during reset, and registers all pins with matched latency.

Parameters:
- BPC_IN, 4, colour bits per channel from the core.
- BPC_OUT, 2, colour bits per channel at the pins. Must satisfy BPC_OUT <= BPC_IN.
- HOLD_CYCLES, 3, clk48 cycles core_rst_n stays low after rst deasserts (0 allowed).
- HSYNC_NEG, 1, 1 = hsync pin is active-low.
- VSYNC_NEG, 1, 1 = vsync pin is active-low.

Ports:
- clk48  in  1  system clock, 48 MHz.
- rst  in  1  synchronous, active-high reset.
- core_rst_n  out  1  stretched active-low reset for the core.
- r_in, g_in, b_in  in  BPC_IN each  core colour.
- de_in  in  1  display enable, 1 = active pixel.
- hsync_in, vsync_in  in  1 each  core syncs, active-high (logical).
- r_out, g_out, b_out  out  BPC_OUT each  pin colour.
- hsync_out, vsync_out  out  1 each  pin syncs, polarity applied.

Behaviour:
- Reset stretcher:
  - Counter hold_cnt has FPGA init value HOLD_CYCLES, so the core is held in reset at configuration even if rst never asserts.
  - rst=1 loads HOLD_CYCLES; otherwise hold_cnt decrements and saturates at 0.
  - core_rst_n is registered: it equals (hold_cnt==0 && !rst) from the previous cycle. Reset value 0.
  - rst re-asserted mid-operation: core_rst_n drops on the next edge and the full hold restarts.
- Pipeline, 2 stages:
  - S1 registers the inputs and the dither offset.
  - S2 computes the quantised colour and drives the pins.
  - Every output lags its input by exactly 2 cycles; syncs are delayed identically to colour.
- Blanking:
  - While rst=1 or core_rst_n=0, S1 captures de=0 and syncs inactive.
  - Pins then show rgb=0 and syncs at inactive level: HSYNC_NEG=1 gives 1, HSYNC_NEG=0 gives 0 (VSYNC_NEG likewise).
  - Reset values of r/g/b_out are 0; sync outputs reset to their inactive level.
- de_in=0 forces r/g/b_out=0 at the matching output cycle.
- Position parity for dither:
  - px toggles on every de_in=1 cycle and clears on each de_in 0->1 edge, so the first pixel has px=0.
  - py toggles on each de_in 1->0 edge and clears on the vsync_in 0->1 edge.
  - If both edges occur in the same cycle, the vsync clear wins.
- Quantisation, with D = BPC_IN - BPC_OUT:
  - D=0: pass-through.
  - Otherwise, threshold t = Bayer[py][px] with Bayer = {{0,2},{3,1}}.
  - Offset o = t << (D-2) when D>=2, else t >> (2-D).
  - out = min((in + o) >> D, 2^BPC_OUT - 1). The sum is computed BPC_IN+1 bits wide, so there is no wrap.
  - Full-scale input always yields full-scale output.
- Sync polarity: pin = logical XOR NEG, applied at S2.

Optional Feature:
- Macro VGA_PIN_DITHER_EN.
- Defined: ordered dither as above.
- Undefined: o=0 (pure truncation, out = in >> D), and the px/py logic is removed.
- Latency is 2 cycles in both builds.

Decomposition:
- Package vga_pin_pkg holds:
  - the Bayer 2x2 constant table;
  - a function for the offset scaling by D;
  - a localparam helper for counter width, clog2(HOLD_CYCLES+1).
- One sub-module, reset_stretcher (HOLD_CYCLES parameter; ports clk48, rst, core_rst_n), instantiated once.

Test Plan:
- Power-on with no rst pulse, HOLD_CYCLES=3 -> core_rst_n=0 for cycles 0..3, then 1 from cycle 4. During that time hsync_out=vsync_out=1 and rgb=0.
- rst high for 5 cycles mid-frame, then low -> core_rst_n=0 on the first edge after assertion and returns to 1 exactly 4 cycles after rst falls. Pins are blanked from 2 cycles after rst rises.
- Dither undefined, BPC_IN=4, BPC_OUT=2, r_in=4'hB, de=1 -> r_out=2'b10 two cycles later. Input 4'hF gives 2'b11 and never wraps.
- Dither defined, r_in=4'h5 held over a 2x2 block (two lines, pixels x=0,1) -> offsets 0,2,3,1 give r_out 1,1,2,1 respectively. Input 4'hF gives 3 at every position.
- HSYNC_NEG=0, VSYNC_NEG=1, hsync_in/vsync_in pulse high for 1 cycle -> hsync_out high and vsync_out low for exactly 1 cycle, 2 cycles later, aligned with the colour of the same input cycle.
- de_in=0 with r_in=4'hF -> r_out=0. A de 0->1 edge in the same cycle as a vsync rise -> first pixel uses py=0, px=0 (offset 0).
